// File: rtl/fc_relu_requant.sv
// ReLU + round-half-up requantizer for the fc result stream, with a 2-entry
// output buffer, M-element vector framing and a sticky saturation flag.
module fc_relu_requant #(
   parameter int M     = 4,
   parameter int T     = 16,
   parameter int TO    = 8,
   parameter int SHIFT = 4,
   parameter int RELU  = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          input_valid,
   output logic          input_ready,
   input  logic [T-1:0]  input_data,
   output logic          output_valid,
   input  logic          output_ready,
   output logic [TO-1:0] output_data,
   output logic          output_last,
   output logic          sat_flag
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic signed [T:0] MAXV = (T+1)'((2**(TO-1)) - 1);
   localparam logic signed [T:0] MINV = ~MAXV;

   logic signed [T:0] r_ext, q;
   logic          sat_hi, sat_lo;
   logic [TO-1:0] res;
   logic          push, pop;

   logic [1:0]    occ_q, occ_d;
   logic [TO-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic          rdy_q;

   // One extra bit of headroom so the rounding add never overflows.
   assign r_ext = (RELU != 0 && input_data[T-1]) ? '0 : {input_data[T-1], input_data};

   generate
      if (SHIFT > 0) begin : g_rnd
         localparam logic signed [T:0] RND = (T+1)'(1) <<< (SHIFT - 1);
         assign q = (r_ext + RND) >>> SHIFT;
      end else begin : g_pass
         assign q = r_ext;
      end
   endgenerate

   assign sat_hi = (q > MAXV);
   assign sat_lo = (q < MINV);
   assign res    = sat_hi ? MAXV[TO-1:0] : (sat_lo ? MINV[TO-1:0] : q[TO-1:0]);

   assign push = input_valid && rdy_q;
   assign pop  = output_valid && output_ready;

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      sat_d  = sat_q;
      if (push && (sat_hi || sat_lo)) sat_d = 1'b1;
      if (pop) cnt_d = (cnt_q == CW'(M - 1)) ? '0 : cnt_q + CW'(1);
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = res;
            else               tail_d = res;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         // push+pop only happens at occupancy 1: the new element replaces the head
         2'b11: head_d = res;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
         rdy_q  <= (occ_d != 2'd2);
      end
   end

   assign input_ready  = rdy_q;
   assign output_valid = (occ_q != 2'd0);
   assign output_data  = output_valid ? head_q : '0;
   assign output_last  = output_valid && (cnt_q == CW'(M - 1));
   assign sat_flag     = sat_q;

endmodule

// File: tb/tb_fc_relu_requant.sv
// Directed bench: default config (d0), RELU off (d1), pass-through 16-bit (d2).
module tb_fc_relu_requant;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // d0: defaults
   logic vld0 = 1'b0, rdy0, ov0, ordy0 = 1'b0, ol0, sf0;
   logic [15:0] din0 = '0;
   logic signed [7:0] od0;
   // d1: RELU=0
   logic vld1 = 1'b0, rdy1, ov1, ordy1 = 1'b1, ol1, sf1;
   logic [15:0] din1 = '0;
   logic signed [7:0] od1;
   // d2: SHIFT=0, TO=16, RELU=0
   logic vld2 = 1'b0, rdy2, ov2, ordy2 = 1'b1, ol2, sf2;
   logic [15:0] din2 = '0;
   logic signed [15:0] od2;

   fc_relu_requant d0 (
      .clk(clk), .reset(reset), .input_valid(vld0), .input_ready(rdy0), .input_data(din0),
      .output_valid(ov0), .output_ready(ordy0), .output_data(od0), .output_last(ol0), .sat_flag(sf0));

   fc_relu_requant #(.RELU(0)) d1 (
      .clk(clk), .reset(reset), .input_valid(vld1), .input_ready(rdy1), .input_data(din1),
      .output_valid(ov1), .output_ready(ordy1), .output_data(od1), .output_last(ol1), .sat_flag(sf1));

   fc_relu_requant #(.SHIFT(0), .TO(16), .RELU(0)) d2 (
      .clk(clk), .reset(reset), .input_valid(vld2), .input_ready(rdy2), .input_data(din2),
      .output_valid(ov2), .output_ready(ordy2), .output_data(od2), .output_last(ol2), .sat_flag(sf2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", rdy0); end
      checks++; if (ov0 !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b exp 0", ov0); end
      checks++; if (od0 !== 8'sd0) begin errors++; $display("FAIL reset_data got %0d exp 0", od0); end
      checks++; if (ol0 !== 1'b0)  begin errors++; $display("FAIL reset_last got %0b exp 0", ol0); end
      checks++; if (sf0 !== 1'b0)  begin errors++; $display("FAIL reset_sat got %0b exp 0", sf0); end
      reset = 1'b0;
      tick();
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL release_ready got %0b exp 1", rdy0); end
   endtask

   task automatic test_defaults();
      int xin[4]  = '{1000, 5000, -300, 16};
      int xexp[4] = '{63, 127, 0, 1};
      ordy0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld0 = 1'b1; din0 = 16'(xin[i]);
         tick();
         checks++; if (ov0 !== 1'b1 || od0 !== 8'(xexp[i]))
            begin errors++; $display("FAIL dflt_data[%0d] got %0d v%0b exp %0d", i, od0, ov0, xexp[i]); end
         checks++; if (ol0 !== (i == 3))
            begin errors++; $display("FAIL dflt_last[%0d] got %0b exp %0b", i, ol0, (i == 3)); end
         checks++; if (sf0 !== (i >= 1))
            begin errors++; $display("FAIL dflt_sat[%0d] got %0b exp %0b", i, sf0, (i >= 1)); end
      end
      vld0 = 1'b0;
      tick();
      checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL dflt_drain got %0b exp 0", ov0); end
   endtask

   task automatic test_relu_off();
      int xin[3]  = '{-300, -32768, 32767};
      int xexp[3] = '{-19, -128, 127};
      for (int i = 0; i < 3; i++) begin
         vld1 = 1'b1; din1 = 16'(xin[i]);
         tick();
         checks++; if (ov1 !== 1'b1 || od1 !== 8'(xexp[i]))
            begin errors++; $display("FAIL relu0_data[%0d] got %0d exp %0d", i, od1, xexp[i]); end
         checks++; if (sf1 !== (i >= 1))
            begin errors++; $display("FAIL relu0_sat[%0d] got %0b exp %0b", i, sf1, (i >= 1)); end
         checks++; if (ol1 !== 1'b0)
            begin errors++; $display("FAIL relu0_last[%0d] got %0b exp 0", i, ol1); end
      end
      vld1 = 1'b0;
   endtask

   task automatic test_shift0();
      int xin[2] = '{-5, 32767};
      for (int i = 0; i < 2; i++) begin
         vld2 = 1'b1; din2 = 16'(xin[i]);
         tick();
         checks++; if (ov2 !== 1'b1 || od2 !== 16'(xin[i]))
            begin errors++; $display("FAIL pass_data[%0d] got %0d exp %0d", i, od2, xin[i]); end
         checks++; if (sf2 !== 1'b0)
            begin errors++; $display("FAIL pass_sat[%0d] got %0b exp 0", i, sf2); end
      end
      vld2 = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      ordy0 = 1'b0;
      vld0 = 1'b1; din0 = 16'd100;             // -> 6
      tick();
      checks++; if (rdy0 !== 1'b1 || ov0 !== 1'b1 || od0 !== 8'sd6)
         begin errors++; $display("FAIL bp_first got r%0b v%0b %0d exp r1 v1 6", rdy0, ov0, od0); end
      din0 = 16'd200;                          // -> 13
      tick();
      checks++; if (rdy0 !== 1'b0 || od0 !== 8'sd6)
         begin errors++; $display("FAIL bp_full got r%0b %0d exp r0 6", rdy0, od0); end
      din0 = 16'd300;                          // -> 19, blocked for now
      tick();
      checks++; if (rdy0 !== 1'b0 || ov0 !== 1'b1 || od0 !== 8'sd6)
         begin errors++; $display("FAIL bp_hold got r%0b v%0b %0d exp r0 v1 6", rdy0, ov0, od0); end
      ordy0 = 1'b1;
      tick();
      checks++; if (rdy0 !== 1'b1 || od0 !== 8'sd13)
         begin errors++; $display("FAIL bp_pop1 got r%0b %0d exp r1 13", rdy0, od0); end
      tick();
      checks++; if (ov0 !== 1'b1 || od0 !== 8'sd19)
         begin errors++; $display("FAIL bp_pop2 got v%0b %0d exp v1 19", ov0, od0); end
      vld0 = 1'b0;
      tick();
      checks++; if (ov0 !== 1'b0)
         begin errors++; $display("FAIL bp_drain got %0b exp 0", ov0); end
   endtask

   task automatic test_framing();
      int sent = 0, nrx = 0, cyc = 0;
      logic acc;
      do_reset();
      while (nrx < 12 && cyc < 300) begin
         vld0  = (sent < 12);
         din0  = 16'(16 * (sent + 1));         // element k requantizes to k
         ordy0 = (nrx >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
         acc   = vld0 && rdy0;
         if (ov0 && ordy0) begin
            nrx++;
            checks++; if (od0 !== 8'(nrx))
               begin errors++; $display("FAIL frame_data[%0d] got %0d exp %0d", nrx, od0, nrx); end
            checks++; if (ol0 !== (nrx % 4 == 0))
               begin errors++; $display("FAIL frame_last[%0d] got %0b exp %0b", nrx, ol0, (nrx % 4 == 0)); end
         end
         tick();
         if (acc) sent++;
         cyc++;
      end
      vld0 = 1'b0;
      checks++; if (nrx != 12)
         begin errors++; $display("FAIL frame_timeout got %0d transfers exp 12", nrx); end
   endtask

   task automatic test_reset_mid();
      ordy0 = 1'b0;
      vld0 = 1'b1; din0 = 16'd5000;
      tick();
      din0 = 16'd1000;
      tick();
      vld0 = 1'b0;
      checks++; if (rdy0 !== 1'b0 || sf0 !== 1'b1)
         begin errors++; $display("FAIL mid_setup got r%0b s%0b exp r0 s1", rdy0, sf0); end
      reset = 1'b1;
      tick();
      checks++; if (ov0 !== 1'b0 || sf0 !== 1'b0 || rdy0 !== 1'b0)
         begin errors++; $display("FAIL mid_reset got v%0b s%0b r%0b exp 0 0 0", ov0, sf0, rdy0); end
      reset = 1'b0;
      tick();
      checks++; if (rdy0 !== 1'b1 || ov0 !== 1'b0)
         begin errors++; $display("FAIL mid_release got r%0b v%0b exp r1 v0", rdy0, ov0); end
      ordy0 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         vld0 = 1'b1; din0 = 16'(16 * i);
         tick();
         checks++; if (od0 !== 8'(i) || ol0 !== (i == 4))
            begin errors++; $display("FAIL mid_vec[%0d] got %0d l%0b exp %0d l%0b", i, od0, ol0, i, (i == 4)); end
      end
      vld0 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_relu_off();
      test_shift0();
      test_back_to_back();
      test_framing();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
